// File: rtl/display_arbiter.sv
// Arbitrates the shared 8-digit display between playback time, volume and track overlays,
// and produces the blink mask while playback is paused.
module display_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 200_000_000,
  parameter int unsigned BLINK_CYCLES = 50_000_000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] TIME_DATA,
  input  logic        VOL_REQ,
  input  logic [15:0] VOL_DATA,
  input  logic        TRACK_REQ,
  input  logic [15:0] TRACK_DATA,
  input  logic        PAUSED,
  output logic [15:0] DATA,
  output logic [1:0]  MODE,
  output logic        BLANK
);

  localparam int unsigned TimerW = $clog2(HOLD_CYCLES);
  localparam int unsigned BlinkW = $clog2(BLINK_CYCLES);
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(HOLD_CYCLES - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    StTime  = 2'd0,
    StVol   = 2'd1,
    StTrack = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [15:0]         vol_q, vol_d;
  logic [15:0]         trk_q, trk_d;
  logic                pend_q, pend_d;
  logic [15:0]         pend_val_q, pend_val_d;
  logic [15:0]         data_q, data_d;
  logic [BlinkW-1:0]   blink_q, blink_d;
  logic                blank_q, blank_d;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    vol_d      = vol_q;
    trk_d      = trk_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;

    if (TRACK_REQ) begin
      state_d = StTrack;
      trk_d   = TRACK_DATA;
      timer_d = TimerLoad;
      if (VOL_REQ) begin
        pend_d     = 1'b1;
        pend_val_d = VOL_DATA;
      end
    end else if (VOL_REQ) begin
      if (state_q == StTrack) begin
        pend_d     = 1'b1;
        pend_val_d = VOL_DATA;
        // Track overlay keeps running; hold at zero so it expires on the next quiet cycle.
        if (timer_q != '0) timer_d = timer_q - 1'b1;
      end else begin
        state_d = StVol;
        vol_d   = VOL_DATA;
        timer_d = TimerLoad;
      end
    end else if (state_q != StTime) begin
      if (timer_q == '0) begin
        if (state_q == StTrack && pend_q) begin
          state_d = StVol;
          vol_d   = pend_val_q;
          pend_d  = 1'b0;
          timer_d = TimerLoad;
        end else begin
          state_d = StTime;
        end
      end else begin
        timer_d = timer_q - 1'b1;
      end
    end
  end

  always_comb begin
    unique case (state_d)
      StVol:   data_d = vol_d;
      StTrack: data_d = trk_d;
      default: data_d = TIME_DATA;
    endcase
  end

  // Blink only runs while staying in paused TIME; any overlay (including its entry edge) clears it.
  always_comb begin
    blink_d = '0;
    blank_d = 1'b0;
    if (PAUSED && state_q == StTime && state_d == StTime) begin
      if (blink_q == BlinkLast) begin
        blink_d = '0;
        blank_d = ~blank_q;
      end else begin
        blink_d = blink_q + 1'b1;
        blank_d = blank_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= StTime;
      timer_q    <= '0;
      vol_q      <= '0;
      trk_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      data_q     <= '0;
      blink_q    <= '0;
      blank_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      vol_q      <= vol_d;
      trk_q      <= trk_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      data_q     <= data_d;
      blink_q    <= blink_d;
      blank_q    <= blank_d;
    end
  end

  assign DATA  = data_q;
  assign MODE  = state_q;
  assign BLANK = blank_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed self-checking bench for display_arbiter with short hold and blink periods.
module tb_display_arbiter;

  localparam int unsigned Hold  = 10;
  localparam int unsigned Blink = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] time_data;
  logic        vol_req;
  logic [15:0] vol_data;
  logic        track_req;
  logic [15:0] track_data;
  logic        paused;
  logic [15:0] data;
  logic [1:0]  mode;
  logic        blank;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  display_arbiter #(
    .HOLD_CYCLES  (Hold),
    .BLINK_CYCLES (Blink)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .TIME_DATA  (time_data),
    .VOL_REQ    (vol_req),
    .VOL_DATA   (vol_data),
    .TRACK_REQ  (track_req),
    .TRACK_DATA (track_data),
    .PAUSED     (paused),
    .DATA       (data),
    .MODE       (mode),
    .BLANK      (blank)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_view(input string tag, input int unsigned exp_mode,
                            input int unsigned exp_data);
    check_eq({tag, " MODE"}, 32'(mode), 32'(exp_mode));
    check_eq({tag, " DATA"}, 32'(data), 32'(exp_data));
  endtask

  initial begin
    rst_n      = 1'b0;
    time_data  = 16'd75;
    vol_req    = 1'b0;
    vol_data   = 16'd0;
    track_req  = 1'b0;
    track_data = 16'd0;
    paused     = 1'b0;

    // Reset and time view
    for (int i = 0; i < 3; i++) begin
      step();
      check_view("reset", 0, 0);
      check_eq("reset BLANK", 32'(blank), 0);
    end
    rst_n = 1'b1;
    step();
    check_view("time75", 0, 75);
    time_data = 16'd76;
    step();
    check_view("time76", 0, 76);

    // Volume overlay, with data change without request
    vol_req  = 1'b1;
    vol_data = 16'd7;
    step();
    vol_req  = 1'b0;
    vol_data = 16'd9;
    for (int k = 1; k <= Hold; k++) begin
      check_view("vol7", 1, 7);
      if (k == Hold) time_data = 16'd100;
      step();
    end
    check_view("vol end", 0, 100);

    // Retrigger at cycle 6
    for (int c = 0; c <= 17; c++) begin
      vol_req  = (c == 0 || c == 6);
      vol_data = (c == 0) ? 16'd5 : 16'd6;
      step();
      vol_req = 1'b0;
      if (c + 1 <= 6)       check_view("retrig a", 1, 5);
      else if (c + 1 <= 16) check_view("retrig b", 1, 6);
      else                  check_view("retrig end", 0, 100);
    end

    // Simultaneous track+volume: track then pending volume
    track_req  = 1'b1;
    track_data = 16'd3;
    vol_req    = 1'b1;
    vol_data   = 16'd4;
    step();
    track_req  = 1'b0;
    vol_req    = 1'b0;
    vol_data   = 16'd55;
    track_data = 16'd66;
    for (int k = 1; k <= 22; k++) begin
      if (k <= 10)      check_view("simul trk", 2, 3);
      else if (k <= 20) check_view("simul vol", 1, 4);
      else              check_view("simul end", 0, 100);
      step();
    end

    // Preemption of a volume overlay by a track change
    for (int c = 0; c <= 15; c++) begin
      vol_req    = (c == 0);
      vol_data   = 16'd2;
      track_req  = (c == 3);
      track_data = 16'd8;
      step();
      vol_req   = 1'b0;
      track_req = 1'b0;
      if (c + 1 <= 3)       check_view("preempt vol", 1, 2);
      else if (c + 1 <= 13) check_view("preempt trk", 2, 8);
      else                  check_view("preempt end", 0, 100);
    end

    // Pause blink, interrupted by a volume overlay at cycle 13
    paused = 1'b1;
    for (int c = 0; c <= 35; c++) begin
      int k;
      int unsigned exp_blank;
      vol_req  = (c == 13);
      vol_data = 16'd21;
      step();
      vol_req = 1'b0;
      k = c + 1;
      if (k <= 13)      exp_blank = (k / 4) % 2;
      else if (k <= 23) exp_blank = 0;
      else              exp_blank = ((k - 24) / 4) % 2;
      check_eq("blink BLANK", 32'(blank), 32'(exp_blank));
      if (k >= 14 && k <= 23) check_view("blink ovl", 1, 21);
    end
    paused = 1'b0;
    step();
    check_eq("unpause BLANK", 32'(blank), 0);

    // Reset mid-overlay drops the pending volume
    track_req  = 1'b1;
    track_data = 16'd11;
    vol_req    = 1'b1;
    vol_data   = 16'd12;
    step();
    track_req = 1'b0;
    vol_req   = 1'b0;
    check_view("pre-reset", 2, 11);
    rst_n = 1'b0;
    step();
    check_view("mid reset", 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step();
      check_view("post reset", 0, 100);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
